// File: rtl/lsu_mem_port_if.sv
// Pipeline request/response channel plus the data-RAM port of the LSU.
// slave: the LSU side. master: the pipeline plus RAM side (testbench).
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read_enable;
    logic [3:0]  mem_write_byte_select;
    logic [3:0]  mem_read_byte_select;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_enable, mem_write_byte_select, mem_read_byte_select,
               mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_enable, mem_write_byte_select, mem_read_byte_select,
               mem_address, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store unit port to a word-wide data RAM.
// Handles byte/half/word lane selection, store replication, load extension,
// range/ROM/funct3 faults. Optional macro LSU_MISALIGN_TRAP_EN faults
// misaligned halfword/word accesses instead of silently aligning them.
module lsu_mem_port #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] ROM_ADDR0 = 32'h00100000,
    parameter logic [31:0] ROM_ADDR1 = 32'h00100004
) (
    input logic          clk,
    input logic          rst,
    lsu_mem_port_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] word_idx;
    logic [31:0] word_addr;
    logic        is_rom, range_fault, illegal_f3, misalign, fault, issue_ok;
    logic [3:0]  lane_mask;
    logic [31:0] store_data;
    logic [31:0] load_fmt;
    logic [31:0] byte_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Fault decode, lane mask and data steering from the latched request
    always_comb begin
        word_addr   = {addr_q[31:2], 2'b00};
        word_idx    = {2'b00, addr_q[31:2]};
        is_rom      = (word_addr == ROM_ADDR0) || (word_addr == ROM_ADDR1);
        range_fault = (word_idx >= MEM_WORDS) && !is_rom;
        // 011/11x never legal; unsigned widths make no sense for stores
        illegal_f3  = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11) || (we_q && funct3_q[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign    = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        misalign    = 1'b0;
`endif
        fault       = range_fault || illegal_f3 || misalign || (we_q && is_rom);

        case (funct3_q[1:0])
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase

        // Replication puts the datum on every lane; the mask picks the real one
        case (funct3_q[1:0])
            2'b00:   store_data = {4{wdata_q[7:0]}};
            2'b01:   store_data = {2{wdata_q[15:0]}};
            default: store_data = wdata_q;
        endcase

        byte_src = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        ld_byte  = byte_src[7:0];
        ld_half  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = bus.mem_rdata;
        endcase
    end

    // Next-state and response capture
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    err_d    = 1'b0;
                    rdata_d  = 32'h0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fault) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                rdata_d = load_fmt;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request/response registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs: memory strobes only in a non-faulting ISSUE, response only in RESP
    always_comb begin
        issue_ok                  = (state_q == S_ISSUE) && !fault;
        bus.req_ready             = (state_q == S_IDLE);
        bus.resp_valid            = (state_q == S_RESP);
        bus.resp_err              = (state_q == S_RESP) && err_q;
        bus.resp_rdata            = (state_q == S_RESP) ? rdata_q : 32'h0;
        bus.mem_read_enable       = issue_ok && !we_q;
        bus.mem_read_byte_select  = (issue_ok && !we_q) ? lane_mask : 4'b0000;
        bus.mem_write_byte_select = (issue_ok && we_q) ? lane_mask : 4'b0000;
        bus.mem_address           = issue_ok ? word_addr : 32'h0;
        bus.mem_wdata             = (issue_ok && we_q) ? store_data : 32'h0;
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port: byte-addressed reference memory,
// behavioural RAM/ROM responder, directed scenarios then random traffic.
module tb_lsu_mem_port;
    localparam logic [31:0] ROM0     = 32'h00100000;
    localparam logic [31:0] ROM1     = 32'h00100004;
    localparam logic [31:0] ROM0_VAL = 32'h8E3D5A17;
    localparam logic [31:0] ROM1_VAL = 32'h009F7CF4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] ram  [0:1023];
    logic [7:0]  refb [0:4095];

    logic [31:0] last_rdata, last_wdata;
    logic [3:0]  last_wlanes, last_rlanes;
    logic        last_err;
    int          last_lat;

    lsu_mem_port_if bus();

    lsu_mem_port #(.MEM_WORDS(1024), .ROM_ADDR0(ROM0), .ROM_ADDR1(ROM1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // RAM/ROM responder: data one cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        if (rst && !init_done) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_write_byte_select[i])
                    ram[bus.mem_address[11:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
        if (bus.mem_read_enable) begin
            if (bus.mem_address == ROM0)      bus.mem_rdata <= ROM0_VAL;
            else if (bus.mem_address == ROM1) bus.mem_rdata <= ROM1_VAL;
            else                              bus.mem_rdata <= ram[bus.mem_address[11:2]];
        end else begin
            bus.mem_rdata <= $urandom;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if ({a[31:2], 2'b00} == ROM0)      w = ROM0_VAL >> (8 * a[1:0]);
        else if ({a[31:2], 2'b00} == ROM1) w = ROM1_VAL >> (8 * a[1:0]);
        else                               w = {24'h0, refb[a[11:0]]};
        return w[7:0];
    endfunction

    // One full access: expectations from byte-level rules, then drive and observe
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int hold);
        int size, exp_lat, lat, rd_cnt, wr_cnt;
        logic is_rom, range_f, illegal, mis, err, seen;
        logic [31:0] eff, exp_rd, exp_wd, obs_wdata, obs_addr;
        logic [3:0] lanes, obs_rl, obs_wl;

        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        eff     = addr & ~32'(size - 1);
        is_rom  = ({addr[31:2], 2'b00} == ROM0) || ({addr[31:2], 2'b00} == ROM1);
        range_f = ((addr >> 2) >= 32'd1024) && !is_rom;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        mis     = (addr != eff);
`else
        mis     = 1'b0;
`endif
        err     = illegal || range_f || mis || (we && is_rom);
        lanes   = 4'b0000;
        for (int i = 0; i < size; i++) lanes[int'(eff[1:0]) + i] = 1'b1;
        exp_rd  = 32'h0;
        if (!we && !err) begin
            for (int i = 0; i < size; i++) exp_rd[8*i +: 8] = ref_byte(eff + 32'(i));
            if (!f3[2] && size < 4 && exp_rd[8*size-1])
                for (int i = size; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
        end
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
        exp_lat = (err || we) ? 2 : 3;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        check("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
        lat = 0; seen = 1'b0; rd_cnt = 0; wr_cnt = 0;
        obs_rl = 4'b0; obs_wl = 4'b0; obs_wdata = 32'h0; obs_addr = 32'h0;
        while (!seen && lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            // Junk requests while busy must be ignored
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_we     = 1'($urandom_range(0, 1));
            bus.req_funct3 = 3'($urandom_range(0, 7));
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            if (bus.mem_read_enable) begin
                rd_cnt++;
                obs_rl   = bus.mem_read_byte_select;
                obs_addr = bus.mem_address;
            end
            if (bus.mem_write_byte_select != 4'b0) begin
                wr_cnt++;
                obs_wl    = bus.mem_write_byte_select;
                obs_wdata = bus.mem_wdata;
                obs_addr  = bus.mem_address;
            end
            if (bus.resp_valid) seen = 1'b1;
        end
        bus.req_valid = 1'b0;
        if (!seen) check("resp_timeout", 32'(lat), 32'(exp_lat));
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", {31'h0, bus.resp_err}, {31'h0, err});
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("rd_strobes", 32'(rd_cnt), (!err && !we) ? 32'h1 : 32'h0);
        check("wr_strobes", 32'(wr_cnt), (!err && we) ? 32'h1 : 32'h0);
        check("rd_lanes", {28'h0, obs_rl}, {28'h0, (!err && !we) ? lanes : 4'b0});
        check("wr_lanes", {28'h0, obs_wl}, {28'h0, (!err && we) ? lanes : 4'b0});
        if (!err) check("mem_address", obs_addr, {addr[31:2], 2'b00});
        if (!err && we) check("mem_wdata", obs_wdata, exp_wd);

        last_rdata = bus.resp_rdata; last_err = bus.resp_err; last_lat = lat;
        last_wlanes = obs_wl; last_rlanes = obs_rl; last_wdata = obs_wdata;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'h0, bus.resp_valid}, 32'h1);
            check("hold_rdata", bus.resp_rdata, exp_rd);
            check("hold_err", {31'h0, bus.resp_err}, {31'h0, err});
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_drop", {31'h0, bus.resp_valid}, 32'h0);
        check("ready_back", {31'h0, bus.req_ready}, 32'h1);

        if (we && !err)
            for (int i = 0; i < size; i++) refb[eff[11:0] + 12'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        logic [31:0] a, w;
        logic [2:0]  f;
        logic        we;
        int          r;
        logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        for (int i = 0; i < 4096; i++) refb[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_mem_re", {31'h0, bus.mem_read_enable}, 32'h0);
        rst = 1'b0;
        init_done = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_outs", {bus.mem_write_byte_select, bus.mem_read_byte_select},
              8'h00);
        check("rst_mem_addr", bus.mem_address | bus.mem_wdata, 32'h0);

        // Word store/load round trip
        do_access(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 0);
        check("sw_lanes", {28'h0, last_wlanes}, 32'hF);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_data", last_rdata, 32'hA1B2C3D4);
        check("lw_lat", 32'(last_lat), 32'd3);

        // Byte store, signed and unsigned byte loads
        do_access(1'b1, 3'b000, 32'h13, 32'h000000F0, 0);
        check("sb_lanes", {28'h0, last_wlanes}, 32'h8);
        check("sb_wdata", last_wdata, 32'hF0F0F0F0);
        do_access(1'b0, 3'b000, 32'h13, 32'h0, 1);
        check("lb_data", last_rdata, 32'hFFFFFFF0);
        do_access(1'b0, 3'b100, 32'h13, 32'h0, 0);
        check("lbu_data", last_rdata, 32'h000000F0);

        // ROM: readable, not writable
        do_access(1'b0, 3'b010, ROM1, 32'h0, 0);
        check("rom_lw_err", {31'h0, last_err}, 32'h0);
        check("rom_lw_data", last_rdata, 32'h009F7CF4);
        do_access(1'b1, 3'b010, ROM1, 32'h12345678, 0);
        check("rom_sw_err", {31'h0, last_err}, 32'h1);
        check("rom_sw_lanes", {28'h0, last_wlanes}, 32'h0);

        // Misaligned halfword
        do_access(1'b0, 3'b001, 32'h11, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lh_mis_err", {31'h0, last_err}, 32'h1);
        check("lh_mis_lat", 32'(last_lat), 32'd2);
`else
        check("lh_mis_lanes", {28'h0, last_rlanes}, 32'h3);
        check("lh_mis_data", last_rdata, 32'hFFFFC3D4);
`endif

        // Out-of-range load with backpressure
        do_access(1'b0, 3'b010, 32'h1000, 32'h0, 4);
        check("range_err", {31'h0, last_err}, 32'h1);
        check("range_rdata", last_rdata, 32'h0);

        // Reset while waiting for load data
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_issue_re", {31'h0, bus.mem_read_enable}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        check("mid_rst_rdata", bus.resp_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_valid", {31'h0, bus.resp_valid}, 32'h0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      a = 32'($urandom_range(0, 63));
            else if (r == 7) a = ROM0 + 32'($urandom_range(0, 7));
            else if (r == 8) a = ROM1 + 32'($urandom_range(0, 3));
            else             a = $urandom | 32'h00001000;
            if ($urandom_range(0, 3) != 0) f = legal[$urandom_range(0, 4)];
            else                           f = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            w  = $urandom;
            do_access(we, f, a, w, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
